cpu_run_controller: RTL



---
 rtl/cpu_run_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_controller.sv
// Run sequencer for the single-cycle core: streams a program into imem, runs the core, stops on halt or cycle limit.
// Optional single-step control is compiled in with `define CPU_STEP_EN.
module cpu_run_controller #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LIMIT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_rst,
  input  logic [31:0]        cpu_pc,
  input  logic [15:0]        cpu_max,
  input  logic [LIMIT_W-1:0] cycle_limit,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [15:0]        result,
`ifdef CPU_STEP_EN
  input  logic               step_mode,
  input  logic               step,
  output logic               cpu_en,
`endif
  output logic [2:0]         dbg_state
);

  // Load handshake: a word transfers on any rising edge where load_valid and
  // load_ready are both high; load_ready is only ever high in LOAD.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_wcnt;
  logic [LIMIT_W-1:0]   r_cyc;
  logic [LIMIT_W-1:0]   r_limit;
  logic [31:0]          r_prev_pc;
  logic                 r_armed;
  logic                 r_timeout;
  logic [15:0]          r_result;

  logic w_accept;
  logic w_start;
  logic w_adv;
  logic w_halt;
  logic w_limit_hit;
  logic w_last_slot;

  assign w_accept    = (r_state == S_LOAD) && load_valid;
  assign w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_slot = (r_wcnt == {ADDR_W{1'b1}});

`ifdef CPU_STEP_EN
  assign w_adv  = (r_state == S_RUN) && (!step_mode || step);
  assign cpu_en = w_adv;
`else
  assign w_adv  = (r_state == S_RUN);
`endif

  // prev_pc is only meaningful once one enabled RUN cycle has been seen.
  assign w_halt      = w_adv && r_armed && (cpu_pc == r_prev_pc);
  assign w_limit_hit = w_adv && (r_limit != '0) && (r_cyc == (r_limit - LIMIT_W'(1)));

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    cpu_rst    = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (w_accept && (load_last || w_last_slot)) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        busy   = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
        if (w_halt || w_limit_hit) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign imem_we    = w_accept;
  assign imem_addr  = r_wcnt;
  assign imem_wdata = load_data;
  assign timeout    = r_timeout;
  assign result     = r_result;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_cyc     <= '0;
      r_limit   <= '0;
      r_prev_pc <= '0;
      r_armed   <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_next;

      // The word counter saturates; the last slot always ends the load.
      if (w_start)
        r_wcnt <= '0;
      else if (w_accept && !w_last_slot)
        r_wcnt <= r_wcnt + ADDR_W'(1);

      if (r_state == S_RELEASE) begin
        r_cyc   <= '0;
        r_limit <= cycle_limit;
        r_armed <= 1'b0;
      end else if (w_adv) begin
        r_cyc     <= r_cyc + LIMIT_W'(1);
        r_prev_pc <= cpu_pc;
        r_armed   <= 1'b1;
      end

      if (w_start) begin
        r_timeout <= 1'b0;
        r_result  <= '0;
      end else if (w_halt || w_limit_hit) begin
        r_result  <= cpu_max;
        r_timeout <= w_limit_hit && !w_halt;
      end
    end
  end

endmodule
